// File: rtl/id_ex_stage.sv
// id_ex_stage: Y86 ID->EX pipeline register with stall/bubble control and saturating event counters
module id_ex_stage #(
  parameter int ICODE_W = 8,
  parameter int WORD_W = 32,
  parameter int PC_W = 32,
  parameter int REG_W = 8,
  parameter int STAT_W = 4,
  parameter logic [ICODE_W-1:0] NOP_ICODE = 8'h1,
  parameter logic [REG_W-1:0] RNONE = 8'hF,
  parameter logic [STAT_W-1:0] STAT_BUB = 4'h0,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic bubble,
  input  logic cnt_clr,
  input  logic [ICODE_W-1:0] id_icode,
  input  logic [ICODE_W-1:0] id_ifun,
  input  logic [STAT_W-1:0] id_stat,
  input  logic [WORD_W-1:0] id_valA,
  input  logic [WORD_W-1:0] id_valB,
  input  logic [WORD_W-1:0] id_valC,
  input  logic [PC_W-1:0] id_valP,
  input  logic [REG_W-1:0] id_dstE,
  input  logic [REG_W-1:0] id_dstM,
  output logic [ICODE_W-1:0] ex_icode,
  output logic [ICODE_W-1:0] ex_ifun,
  output logic [STAT_W-1:0] ex_stat,
  output logic [WORD_W-1:0] ex_valA,
  output logic [WORD_W-1:0] ex_valB,
  output logic [WORD_W-1:0] ex_valC,
  output logic [PC_W-1:0] ex_valP,
  output logic [REG_W-1:0] ex_dstE,
  output logic [REG_W-1:0] ex_dstM,
  output logic ex_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);
  localparam int BW = 2*ICODE_W + STAT_W + 3*WORD_W + PC_W + 2*REG_W;
  localparam logic [BW-1:0] BUB = {NOP_ICODE, {ICODE_W{1'b0}}, STAT_BUB,
                                   {(3*WORD_W+PC_W){1'b0}}, RNONE, RNONE};
  logic [BW-1:0] ex_q, ex_d, id_bus;
  logic valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
  assign id_bus = {id_icode, id_ifun, id_stat, id_valA, id_valB, id_valC, id_valP, id_dstE, id_dstM};
  always_comb begin
    ex_d = bubble ? BUB : stall ? ex_q : id_bus;
    valid_d = bubble ? 1'b0 : stall ? valid_q : 1'b1;
    stall_cnt_d = cnt_clr ? '0 : (stall && !bubble && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    bubble_cnt_d = cnt_clr ? '0 : (bubble && !(&bubble_cnt_q)) ? bubble_cnt_q + CNT_W'(1) : bubble_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= BUB;
      valid_q <= 1'b0;
      stall_cnt_q <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      valid_q <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
  assign {ex_icode, ex_ifun, ex_stat, ex_valA, ex_valB, ex_valC, ex_valP, ex_dstE, ex_dstM} = ex_q;
  assign ex_valid = valid_q;
  assign stall_cnt = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
endmodule
